// File: rtl/tlc_pkg.sv
// rtl/tlc_pkg.sv - shared request-state encodings and grant counter width for the traffic controller
package tlc_pkg;

  // Farm-road request states; the encoding is visible on the debug header
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    QUALIFY = 2'b01,
    PENDING = 2'b10,
    SERVICE = 2'b11
  } req_state_t;

  localparam int GRANT_W = 8;
  localparam logic [GRANT_W-1:0] GRANT_MAX = '1;

endpackage

// File: rtl/farm_sensor_conditioner_sync.sv
// rtl/farm_sensor_conditioner_sync.sv - two-flop synchronizer for a single asynchronous input
module farm_sensor_conditioner_sync (
  input  logic Clk,
  input  logic Rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops give the first stage a full cycle to resolve
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/farm_sensor_conditioner.sv
// rtl/farm_sensor_conditioner.sv - debounced farm-road vehicle request with grant counting (optional FARM_SENSOR_STICKY_EN)
import tlc_pkg::*;

module farm_sensor_conditioner #(
  parameter int DEBOUNCE_CYCLES = 5000000
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               sensorRaw,
  input  logic               farmGreen,
  output logic               farmRequest,
  output logic [1:0]         reqState,
  output logic [GRANT_W-1:0] grantCount
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] TERM    = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic          sensorSync;
  req_state_t    state;
  req_state_t    nextState;
  logic [CW-1:0] counter;

  farm_sensor_conditioner_sync u_sync (
    .Clk (Clk),
    .Rst (Rst),
    .d   (sensorRaw),
    .q   (sensorSync)
  );

  // State register
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state: a sensor drop beats terminal count, a green beats a sensor drop
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (sensorSync) nextState = QUALIFY;
      end
      QUALIFY: begin
        if (!sensorSync)          nextState = IDLE;
        else if (counter == TERM) nextState = PENDING;
      end
      PENDING: begin
        if (farmGreen) nextState = SERVICE;
`ifdef FARM_SENSOR_STICKY_EN
        // Request is latched until served
`else
        else if (!sensorSync) nextState = IDLE;
`endif
      end
      SERVICE: begin
        if (!farmGreen) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Debounce counter: cleared on entry to qualification, held at its ceiling
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      counter <= '0;
    end else if (state == IDLE && sensorSync) begin
      counter <= '0;
    end else if (state == QUALIFY && sensorSync && counter != CNT_MAX) begin
      counter <= counter + CW'(1);
    end
  end

  // Saturating count of PENDING->SERVICE grants
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      grantCount <= '0;
    end else if (state == PENDING && farmGreen && grantCount != GRANT_MAX) begin
      grantCount <= grantCount + GRANT_W'(1);
    end
  end

  // Outputs decode the state register only; QUALIFY->PENDING passes through no PENDING-like code
  always_comb begin
    reqState    = state;
    farmRequest = (state == PENDING);
  end

endmodule
